// File: rtl/program_sequencer.sv
`timescale 1ns/1ps
// Program launch sequencer: reset pulse, program copy, settle, run, then halt/done.
// Optional RUN watchdog is enabled by defining PROG_SEQ_WATCHDOG_EN.
module program_sequencer #(
    parameter int CLEAR_CYCLES    = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int COPY_TIMEOUT    = 1024,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  req,
    input  logic        copy_ack,
    input  logic        cpu_halt,
    output logic [31:0] program_selector,
    output logic        cpu_reset,
    output logic        cpu_stall,
    output logic [2:0]  active_prog,
    output logic [2:0]  state,
    output logic [31:0] run_cycles,
    output logic        error,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_COPY   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t      state_reg;
    logic [4:0]  req_q;
    logic [31:0] cnt_reg;
    logic [31:0] selector_reg;
    logic        cpu_reset_reg;
    logic        cpu_stall_reg;
    logic [2:0]  active_prog_reg;
    logic [31:0] run_cycles_reg;
    logic        error_reg;

    logic [4:0]  rise;
    logic [2:0]  launch_id;
    logic        accept;
    logic [31:0] run_inc;

    assign rise = req & ~req_q;

    // Descending scan so the lowest rising bit has the final say.
    always_comb begin
        launch_id = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (rise[i]) begin
                launch_id = 3'(i + 1);
            end
        end
    end

    assign accept = (|rise) && ((state_reg == S_IDLE) || (state_reg == S_RUN) ||
                                (state_reg == S_DONE) || (state_reg == S_ERROR));

    assign run_inc = (run_cycles_reg == 32'hFFFF_FFFF) ? run_cycles_reg : run_cycles_reg + 32'd1;

`ifdef PROG_SEQ_WATCHDOG_EN
    logic timeout_reg;
    assign timeout = timeout_reg;
`else
    logic unused_watchdog;
    assign unused_watchdog = ^32'(WATCHDOG_CYCLES);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            req_q           <= 5'b11111;
            cnt_reg         <= 32'd0;
            selector_reg    <= 32'd0;
            cpu_reset_reg   <= 1'b0;
            cpu_stall_reg   <= 1'b1;
            active_prog_reg <= 3'd0;
            run_cycles_reg  <= 32'd0;
            error_reg       <= 1'b0;
`ifdef PROG_SEQ_WATCHDOG_EN
            timeout_reg     <= 1'b0;
`endif
        end else begin
            // Edges seen while busy are consumed here and never queued.
            req_q <= req;
            if (accept) begin
                state_reg       <= S_CLEAR;
                cnt_reg         <= 32'd0;
                selector_reg    <= 32'd0;
                cpu_reset_reg   <= 1'b1;
                cpu_stall_reg   <= 1'b1;
                active_prog_reg <= launch_id;
                run_cycles_reg  <= 32'd0;
                error_reg       <= 1'b0;
`ifdef PROG_SEQ_WATCHDOG_EN
                timeout_reg     <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    S_CLEAR: begin
                        if (cnt_reg == 32'(CLEAR_CYCLES - 1)) begin
                            state_reg     <= S_COPY;
                            cnt_reg       <= 32'd0;
                            cpu_reset_reg <= 1'b0;
                            selector_reg  <= {29'd0, active_prog_reg};
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
                    S_COPY: begin
                        if (copy_ack) begin
                            state_reg    <= S_SETTLE;
                            cnt_reg      <= 32'd0;
                            selector_reg <= 32'd0;
                        end else if (cnt_reg == 32'(COPY_TIMEOUT - 1)) begin
                            state_reg    <= S_ERROR;
                            cnt_reg      <= 32'd0;
                            selector_reg <= 32'd0;
                            error_reg    <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_reg == 32'(SETTLE_CYCLES - 1)) begin
                            state_reg     <= S_RUN;
                            cnt_reg       <= 32'd0;
                            cpu_stall_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
                    S_RUN: begin
                        run_cycles_reg <= run_inc;
                        if (cpu_halt) begin
                            state_reg     <= S_DONE;
                            cpu_stall_reg <= 1'b1;
                        end
`ifdef PROG_SEQ_WATCHDOG_EN
                        // run_cycles doubles as the watchdog count; halt takes priority.
                        else if (run_cycles_reg == 32'(WATCHDOG_CYCLES - 1)) begin
                            state_reg     <= S_DONE;
                            cpu_stall_reg <= 1'b1;
                            timeout_reg   <= 1'b1;
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign state            = state_reg;
    assign program_selector = selector_reg;
    assign cpu_reset        = cpu_reset_reg;
    assign cpu_stall        = cpu_stall_reg;
    assign active_prog      = active_prog_reg;
    assign run_cycles       = run_cycles_reg;
    assign error            = error_reg;

endmodule

// File: tb/tb_program_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for program_sequencer: expectations are queued per step and
// popped against the registered outputs one time unit after each rising edge.
module tb_program_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_COPY   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic        clock;
    logic        reset_n;
    logic [4:0]  req;
    logic        copy_ack;
    logic        cpu_halt;
    logic [31:0] program_selector;
    logic        cpu_reset;
    logic        cpu_stall;
    logic [2:0]  active_prog;
    logic [2:0]  state;
    logic [31:0] run_cycles;
    logic        error;
    logic        timeout;

    program_sequencer #(
        .CLEAR_CYCLES   (4),
        .SETTLE_CYCLES  (2),
        .COPY_TIMEOUT   (1024),
        .WATCHDOG_CYCLES(16)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req             (req),
        .copy_ack        (copy_ack),
        .cpu_halt        (cpu_halt),
        .program_selector(program_selector),
        .cpu_reset       (cpu_reset),
        .cpu_stall       (cpu_stall),
        .active_prog     (active_prog),
        .state           (state),
        .run_cycles      (run_cycles),
        .error           (error),
        .timeout         (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    bit   bench_done  = 0;

    logic [2:0] exp_active;
    logic       exp_error;
    logic       exp_timeout;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic push_status(input logic [2:0] st, input logic [31:0] run);
        exp_q.push_back('{"state", {29'd0, st}});
        exp_q.push_back('{"program_selector", (st == S_COPY) ? {29'd0, exp_active} : 32'd0});
        exp_q.push_back('{"cpu_reset", {31'd0, (st == S_CLEAR)}});
        exp_q.push_back('{"cpu_stall", {31'd0, (st != S_RUN)}});
        exp_q.push_back('{"active_prog", {29'd0, exp_active}});
        exp_q.push_back('{"run_cycles", run});
        exp_q.push_back('{"error", {31'd0, exp_error}});
        exp_q.push_back('{"timeout", {31'd0, exp_timeout}});
    endtask

    task automatic pop_compare(input logic [31:0] observed);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_value("scoreboard_underflow", observed, ~observed);
        end else begin
            e = exp_q.pop_front();
            check_value(e.tag, observed, e.value);
        end
    endtask

    task automatic pop_status();
        pop_compare({29'd0, state});
        pop_compare(program_selector);
        pop_compare({31'd0, cpu_reset});
        pop_compare({31'd0, cpu_stall});
        pop_compare({29'd0, active_prog});
        pop_compare(run_cycles);
        pop_compare({31'd0, error});
        pop_compare({31'd0, timeout});
    endtask

    task automatic step(input logic [2:0] st, input logic [31:0] run);
        push_status(st, run);
        @(posedge clock);
        #1;
        pop_status();
    endtask

    task automatic expect_now(input logic [2:0] st, input logic [31:0] run);
        push_status(st, run);
        pop_status();
    endtask

    task automatic launch_to_copy();
        step(S_CLEAR, 0);
        repeat (3) step(S_CLEAR, 0);
        step(S_COPY, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        req         = 5'b00001;
        copy_ack    = 1'b0;
        cpu_halt    = 1'b0;
        exp_active  = 3'd0;
        exp_error   = 1'b0;
        exp_timeout = 1'b0;

        #12;
        expect_now(S_IDLE, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Held button through reset release must not launch.
        repeat (3) step(S_IDLE, 0);
        req = 5'b00000;
        step(S_IDLE, 0);
        req = 5'b00001;
        exp_active = 3'd1;
        launch_to_copy();
        step(S_COPY, 0);
        step(S_COPY, 0);
        copy_ack = 1'b1;
        step(S_SETTLE, 0);
        copy_ack = 1'b0;
        step(S_SETTLE, 0);
        step(S_RUN, 0);
        for (int k = 1; k <= 9; k++) step(S_RUN, k);
        cpu_halt = 1'b1;
        step(S_DONE, 10);
        cpu_halt = 1'b0;
        repeat (2) step(S_DONE, 10);

        // Simultaneous bits 1 and 3: lowest wins; a later bit3 edge in COPY is ignored.
        req = 5'b00000;
        step(S_DONE, 10);
        req = 5'b01010;
        exp_active = 3'd2;
        step(S_CLEAR, 0);
        step(S_CLEAR, 0);
        req = 5'b00010;
        step(S_CLEAR, 0);
        step(S_CLEAR, 0);
        step(S_COPY, 0);
        req = 5'b01010;
        step(S_COPY, 0);
        step(S_COPY, 0);
        copy_ack = 1'b1;
        step(S_SETTLE, 0);
        copy_ack = 1'b0;
        step(S_SETTLE, 0);
        step(S_RUN, 0);

        // Copy timeout into ERROR.
        req = 5'b01011;
        exp_active = 3'd1;
        launch_to_copy();
        repeat (1023) step(S_COPY, 0);
        exp_error = 1'b1;
        step(S_ERROR, 0);
        step(S_ERROR, 0);

        // Relaunch from ERROR; ack arriving on the final timeout cycle wins.
        req = 5'b11011;
        exp_active = 3'd5;
        exp_error = 1'b0;
        launch_to_copy();
        repeat (1023) step(S_COPY, 0);
        copy_ack = 1'b1;
        step(S_SETTLE, 0);
        copy_ack = 1'b0;
        step(S_SETTLE, 0);
        step(S_RUN, 0);
        for (int k = 1; k <= 3; k++) step(S_RUN, k);

        // Launch and halt together in RUN: launch wins.
        req = 5'b11111;
        cpu_halt = 1'b1;
        exp_active = 3'd3;
        step(S_CLEAR, 0);
        cpu_halt = 1'b0;
        repeat (3) step(S_CLEAR, 0);
        step(S_COPY, 0);
        step(S_COPY, 0);

        // Asynchronous reset mid-COPY takes effect without a clock edge.
        reset_n = 1'b0;
        #2;
        exp_active = 3'd0;
        expect_now(S_IDLE, 0);
        @(negedge clock);
        reset_n = 1'b1;

        step(S_IDLE, 0);
        req = 5'b00000;
        step(S_IDLE, 0);
        req = 5'b00001;
        exp_active = 3'd1;
        launch_to_copy();
        copy_ack = 1'b1;
        step(S_SETTLE, 0);
        copy_ack = 1'b0;
        step(S_SETTLE, 0);
        step(S_RUN, 0);
`ifdef PROG_SEQ_WATCHDOG_EN
        for (int k = 1; k <= 15; k++) step(S_RUN, k);
        exp_timeout = 1'b1;
        step(S_DONE, 16);
        step(S_DONE, 16);
`else
        for (int k = 1; k <= 20; k++) step(S_RUN, k);
`endif

        check_value("scoreboard_drained", exp_q.size(), 0);
        bench_done = 1'b1;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        if (!bench_done) begin
            $display("FAIL time_limit: bench did not complete, %0d/%0d checks so far", pass_count, check_count);
            $fatal(1, "time limit expired");
        end
    end

endmodule
